// File: rtl/operator_sequencer_pkg.sv
// Shared sizing, slot/voice ID types and sequencer state encoding for operator_sequencer.
// Slot IDs are voice*OPS_PER_VOICE + op; OPS_PER_VOICE is a power of two, so the voice is the ID's upper bits.
package operator_sequencer_pkg;

    localparam int NUM_VOICES          = 16;
    localparam int OPS_PER_VOICE       = 8;
    localparam int VOICE_ID_W          = $clog2(NUM_VOICES);
    localparam int OP_ID_W             = $clog2(OPS_PER_VOICE);
    localparam int VOICE_OPERATOR_ID_W = VOICE_ID_W + OP_ID_W;

    typedef logic [VOICE_ID_W-1:0]          voice_id_t;
    typedef logic [VOICE_OPERATOR_ID_W-1:0] voice_operator_id_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_t;

    function automatic voice_id_t voice_of(input voice_operator_id_t id);
        return id[VOICE_OPERATOR_ID_W-1:OP_ID_W];
    endfunction

endpackage

// File: rtl/note_state_table.sv
// Pending/active per-voice note tables; pending takes host events, active is reloaded at frame start.
// Read result is registered: rd_on reflects the active table as it stands in the cycle after the request.
module note_state_table #(
    parameter int NUM_VOICES = operator_sequencer_pkg::NUM_VOICES
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       wr_vld,
    input  logic [operator_sequencer_pkg::VOICE_ID_W-1:0] wr_voice,
    input  logic                                       wr_on,
    input  logic                                       copy_en,
    input  logic                                       rd_vld,
    input  logic [operator_sequencer_pkg::VOICE_ID_W-1:0] rd_voice,
    output logic                                       rd_on
);

    logic [NUM_VOICES-1:0] pending_q, pending_d;
    logic [NUM_VOICES-1:0] active_q, active_d;
    logic                  rd_on_q, rd_on_d;

    // The copy sees this edge's event, so an event in the last slot of a frame
    // joins the frame that is starting; one in the frame-start cycle waits a frame.
    always_comb begin
        pending_d = pending_q;
        if (wr_vld) begin
            pending_d[wr_voice] = wr_on;
        end
        active_d = copy_en ? pending_d : active_q;
        rd_on_d  = rd_vld & active_d[rd_voice];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            active_q  <= '0;
            rd_on_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            active_q  <= active_d;
            rd_on_q   <= rd_on_d;
        end
    end

    assign rd_on = rd_on_q;

endmodule

// File: rtl/operator_sequencer.sv
// Frame sequencer issuing one voice/operator slot per cycle, with note tables and an algorithm-write port.
// Outputs registered; config writes land one cycle after accept. Optional o_FrameCount under SEQ_FRAME_COUNTER_EN.
module operator_sequencer #(
    parameter int NUM_VOICES    = operator_sequencer_pkg::NUM_VOICES,
    parameter int OPS_PER_VOICE = operator_sequencer_pkg::OPS_PER_VOICE,
    parameter int DRAIN_CYCLES  = 8
) (
`ifdef SEQ_FRAME_COUNTER_EN
    output logic [15:0]                                            o_FrameCount,
`endif
    input  logic                                                   i_Clock,
    input  logic                                                   i_Reset,
    input  logic                                                   i_Enable,
    output logic [operator_sequencer_pkg::VOICE_OPERATOR_ID_W-1:0] o_VoiceOperator,
    output logic                                                   o_Valid,
    output logic                                                   o_NoteOn,
    output logic                                                   o_FrameStart,
    output logic                                                   o_Idle,
    input  logic                                                   i_NoteValid,
    input  logic [operator_sequencer_pkg::VOICE_ID_W-1:0]          i_NoteVoice,
    input  logic                                                   i_NoteOn,
    input  logic                                                   i_CfgValid,
    output logic                                                   o_CfgReady,
    input  logic [operator_sequencer_pkg::VOICE_OPERATOR_ID_W-1:0] i_CfgAddr,
    input  logic [15:0]                                            i_CfgData,
    output logic                                                   o_AlgorithmWriteEnable,
    output logic [operator_sequencer_pkg::VOICE_OPERATOR_ID_W-1:0] o_ConfigWriteAddr,
    output logic [15:0]                                            o_ConfigWriteData
);
    import operator_sequencer_pkg::*;

    localparam voice_operator_id_t LAST_SLOT  = voice_operator_id_t'(NUM_VOICES * OPS_PER_VOICE - 1);
    localparam int                 DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    seq_state_t         state_q, state_d;
    voice_operator_id_t slot_q, slot_d;
    logic               valid_q, valid_d;
    logic               frame_start_q, frame_start_d;
    logic               idle_q, idle_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic               wr_en_q, wr_en_d;
    voice_operator_id_t wr_addr_q, wr_addr_d;
    logic [15:0]        wr_data_q, wr_data_d;
    logic               cfg_rdy;
    logic               cfg_accept;

    // Registered outputs describe the slot being issued in the current cycle,
    // so the *_d values describe the slot issued next.
    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        valid_d       = 1'b0;
        frame_start_d = 1'b0;
        idle_d        = 1'b0;
        drain_cnt_d   = drain_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_Enable) begin
                    state_d       = ST_RUN;
                    slot_d        = '0;
                    valid_d       = 1'b1;
                    frame_start_d = 1'b1;
                end else begin
                    idle_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (slot_q == LAST_SLOT && !i_Enable) begin
                    state_d     = ST_DRAIN;
                    slot_d      = '0;
                    drain_cnt_d = '0;
                end else begin
                    valid_d       = 1'b1;
                    slot_d        = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
                    frame_start_d = (slot_q == LAST_SLOT);
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = ST_IDLE;
                    idle_d  = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idle_d  = 1'b1;
            end
        endcase
    end

    // A write may not target the slot the modulator is reading this cycle.
    assign cfg_rdy    = !(state_q == ST_RUN && i_CfgAddr == slot_q);
    assign cfg_accept = i_CfgValid & cfg_rdy;

    always_comb begin
        wr_en_d   = cfg_accept;
        wr_addr_d = cfg_accept ? i_CfgAddr : wr_addr_q;
        wr_data_d = cfg_accept ? i_CfgData : wr_data_q;
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q       <= ST_IDLE;
            slot_q        <= '0;
            valid_q       <= 1'b0;
            frame_start_q <= 1'b0;
            idle_q        <= 1'b1;
            drain_cnt_q   <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            valid_q       <= valid_d;
            frame_start_q <= frame_start_d;
            idle_q        <= idle_d;
            drain_cnt_q   <= drain_cnt_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
        end
    end

    note_state_table #(
        .NUM_VOICES (NUM_VOICES)
    ) u_note_state_table (
        .clk      (i_Clock),
        .rst      (i_Reset),
        .wr_vld   (i_NoteValid),
        .wr_voice (i_NoteVoice),
        .wr_on    (i_NoteOn),
        .copy_en  (frame_start_d),
        .rd_vld   (valid_d),
        .rd_voice (voice_of(slot_d)),
        .rd_on    (o_NoteOn)
    );

`ifdef SEQ_FRAME_COUNTER_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q + 16'(frame_start_d);
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign o_FrameCount = frame_cnt_q;
`endif

    assign o_VoiceOperator        = slot_q;
    assign o_Valid                = valid_q;
    assign o_FrameStart           = frame_start_q;
    assign o_Idle                 = idle_q;
    assign o_CfgReady             = cfg_rdy;
    assign o_AlgorithmWriteEnable = wr_en_q;
    assign o_ConfigWriteAddr      = wr_addr_q;
    assign o_ConfigWriteData      = wr_data_q;

endmodule

// File: tb/tb_operator_sequencer.sv
// Bench for operator_sequencer: vector table, directed corner sequences and a random run against a frame-level model.
module tb_operator_sequencer;

    localparam int NSLOT = 128;
    localparam int OPV   = 8;
    localparam int DRAIN = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        note_vld;
    logic [3:0]  note_voice;
    logic        note_on;
    logic        cfg_vld;
    logic [6:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic [6:0]  o_VoiceOperator;
    logic        o_Valid, o_NoteOn, o_FrameStart, o_Idle, o_CfgReady, o_AlgorithmWriteEnable;
    logic [6:0]  o_ConfigWriteAddr;
    logic [15:0] o_ConfigWriteData;
`ifdef SEQ_FRAME_COUNTER_EN
    logic [15:0] o_FrameCount;
`endif

    operator_sequencer dut (
`ifdef SEQ_FRAME_COUNTER_EN
        .o_FrameCount           (o_FrameCount),
`endif
        .i_Clock                (clk),
        .i_Reset                (rst),
        .i_Enable               (en),
        .o_VoiceOperator        (o_VoiceOperator),
        .o_Valid                (o_Valid),
        .o_NoteOn               (o_NoteOn),
        .o_FrameStart           (o_FrameStart),
        .o_Idle                 (o_Idle),
        .i_NoteValid            (note_vld),
        .i_NoteVoice            (note_voice),
        .i_NoteOn               (note_on),
        .i_CfgValid             (cfg_vld),
        .o_CfgReady             (o_CfgReady),
        .i_CfgAddr              (cfg_addr),
        .i_CfgData              (cfg_data),
        .o_AlgorithmWriteEnable (o_AlgorithmWriteEnable),
        .o_ConfigWriteAddr      (o_ConfigWriteAddr),
        .o_ConfigWriteData      (o_ConfigWriteData)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Frame-level reference: mode 0 idle, 1 run, 2 drain.
    int m_mode, m_slot, m_drain_left, m_waddr, m_wdata, m_fcnt;
    bit m_fs, m_we;
    bit pend[16];
    bit act[16];

    task automatic chk(input string name, input int act_v, input int exp_v);
        n_cmp++;
        if (act_v != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act_v, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_slot = 0; m_drain_left = 0; m_waddr = 0; m_wdata = 0; m_fcnt = 0;
        m_fs = 0; m_we = 0;
        for (int v = 0; v < 16; v++) begin
            pend[v] = 0;
            act[v]  = 0;
        end
    endtask

    task automatic model_step();
        bit rdy;
        bit new_fs;
        rdy  = !(m_mode == 1 && cfg_addr == m_slot);
        m_we = cfg_vld && rdy;
        if (m_we) begin
            m_waddr = cfg_addr;
            m_wdata = cfg_data;
        end
        if (note_vld) pend[note_voice] = note_on;
        new_fs = 0;
        case (m_mode)
            0: if (en) begin m_mode = 1; m_slot = 0; new_fs = 1; end
            1: begin
                if (m_slot == NSLOT - 1 && !en) begin
                    m_mode = 2; m_drain_left = DRAIN;
                end else begin
                    m_slot = (m_slot + 1) % NSLOT;
                    new_fs = (m_slot == 0);
                end
            end
            default: begin
                m_drain_left--;
                if (m_drain_left == 0) m_mode = 0;
            end
        endcase
        if (new_fs) begin
            act    = pend;
            m_fcnt = (m_fcnt + 1) % 65536;
        end
        m_fs = new_fs;
    endtask

    // Called at posedge+1 with inputs set; returns at the next posedge+1 after checking.
    task automatic tick();
        #1;
        chk("cfg_ready", o_CfgReady, (m_mode == 1 && cfg_addr == m_slot) ? 0 : 1);
        model_step();
        @(posedge clk);
        #1;
        chk("valid", o_Valid, (m_mode == 1) ? 1 : 0);
        chk("idle", o_Idle, (m_mode == 0) ? 1 : 0);
        chk("frame_start", o_FrameStart, m_fs);
        chk("note_on", o_NoteOn, (m_mode == 1) ? act[m_slot / OPV] : 0);
        if (m_mode == 1) chk("slot", o_VoiceOperator, m_slot);
        chk("wr_en", o_AlgorithmWriteEnable, m_we);
        if (m_we) begin
            chk("wr_addr", o_ConfigWriteAddr, m_waddr);
            chk("wr_data", o_ConfigWriteData, m_wdata);
        end
`ifdef SEQ_FRAME_COUNTER_EN
        chk("frame_count", o_FrameCount, m_fcnt);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_valid", o_Valid, 0);
        chk("rst_frame_start", o_FrameStart, 0);
        chk("rst_idle", o_Idle, 1);
        chk("rst_note_on", o_NoteOn, 0);
        chk("rst_slot", o_VoiceOperator, 0);
        chk("rst_wr_en", o_AlgorithmWriteEnable, 0);
        chk("rst_wr_addr", o_ConfigWriteAddr, 0);
        chk("rst_wr_data", o_ConfigWriteData, 0);
        chk("rst_cfg_ready", o_CfgReady, 1);
`ifdef SEQ_FRAME_COUNTER_EN
        chk("rst_frame_count", o_FrameCount, 0);
`endif
        @(posedge clk);
        #1;
        chk("rst_hold_wr_en", o_AlgorithmWriteEnable, 0);
        chk("rst_hold_valid", o_Valid, 0);
        en = 0; note_vld = 0; note_voice = 0; note_on = 0;
        cfg_vld = 0; cfg_addr = 0; cfg_data = 0;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic to_slot(input int s);
        for (int k = 0; k < 300; k++) begin
            if (o_Valid && o_VoiceOperator == s) return;
            tick();
        end
        n_cmp++;
        n_bad++;
        $display("FAIL to_slot_timeout: slot %0d never issued", s);
    endtask

    task automatic count_voice(input int v, output int ones);
        ones = 0;
        to_slot(v * OPV);
        for (int k = 0; k < OPV; k++) begin
            ones += int'(o_NoteOn);
            tick();
        end
    endtask

    task automatic note_event(input int v, input bit on);
        note_vld = 1; note_voice = 4'(v); note_on = on;
        tick();
        note_vld = 0;
    endtask

    typedef struct {
        bit en;
        bit exp_valid;
        int exp_slot;
        bit exp_fs;
        bit exp_idle;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int   fs_cycles[$];
        int   c, nv, nd, last;

        vecs[0] = '{en: 0, exp_valid: 0, exp_slot: 0, exp_fs: 0, exp_idle: 1};
        vecs[1] = '{en: 1, exp_valid: 1, exp_slot: 0, exp_fs: 1, exp_idle: 0};
        vecs[2] = '{en: 1, exp_valid: 1, exp_slot: 1, exp_fs: 0, exp_idle: 0};
        vecs[3] = '{en: 0, exp_valid: 1, exp_slot: 2, exp_fs: 0, exp_idle: 0};
        vecs[4] = '{en: 1, exp_valid: 1, exp_slot: 3, exp_fs: 0, exp_idle: 0};

        en = 0; note_vld = 0; note_voice = 0; note_on = 0;
        cfg_vld = 0; cfg_addr = 0; cfg_data = 0;
        do_reset();

        foreach (vecs[i]) begin
            en = vecs[i].en;
            tick();
            chk("vec_valid", o_Valid, vecs[i].exp_valid);
            chk("vec_slot", o_VoiceOperator, vecs[i].exp_slot);
            chk("vec_fs", o_FrameStart, vecs[i].exp_fs);
            chk("vec_idle", o_Idle, vecs[i].exp_idle);
        end

        // 300 enabled cycles from reset: frame starts land on cycles 1, 129, 257.
        do_reset();
        en = 1;
        for (int t = 1; t <= 300; t++) begin
            tick();
            if (o_FrameStart) fs_cycles.push_back(t);
        end
        chk("fs_count", fs_cycles.size(), 3);
        if (fs_cycles.size() >= 3) begin
            chk("fs_first", fs_cycles[0], 1);
            chk("fs_second", fs_cycles[1], 129);
            chk("fs_third", fs_cycles[2], 257);
        end
`ifdef SEQ_FRAME_COUNTER_EN
        chk("frame_count_3", o_FrameCount, 3);
`endif

        // Config write colliding with the issuing slot.
        to_slot(17);
        cfg_vld = 1; cfg_addr = 7'd17; cfg_data = 16'h07FF;
        #1;
        chk("cfg_collide_ready", o_CfgReady, 0);
        tick();
        chk("cfg_no_write_yet", o_AlgorithmWriteEnable, 0);
        chk("cfg_ready_next", o_CfgReady, 1);
        tick();
        cfg_vld = 0;
        chk("cfg_we_pulse", o_AlgorithmWriteEnable, 1);
        chk("cfg_we_addr", o_ConfigWriteAddr, 17);
        chk("cfg_we_data", o_ConfigWriteData, 16'h07FF);
        tick();
        chk("cfg_we_single", o_AlgorithmWriteEnable, 0);

        // Note tables: frame-boundary copy, copy-cycle event, later event wins.
        count_voice(3, c);
        chk("note_v3_before", c, 0);
        to_slot(50);
        note_event(3, 1);
        count_voice(3, c);
        chk("note_v3_next_frame", c, 8);
        to_slot(0);
        chk("fs_at_slot0", o_FrameStart, 1);
        note_event(3, 0);
        count_voice(3, c);
        chk("note_v3_copy_cycle_deferred", c, 8);
        to_slot(60);
        note_event(7, 0);
        note_event(7, 1);
        count_voice(3, c);
        chk("note_v3_off_landed", c, 0);
        count_voice(7, c);
        chk("note_v7_later_wins", c, 8);

        // Drop enable mid-frame; re-request during drain.
        to_slot(40);
        en = 0;
        nv = 0; nd = 0; last = -1;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (o_Valid) begin
                nv++;
                last = int'(o_VoiceOperator);
            end else if (!o_Idle) begin
                nd++;
                en = 1;
            end else begin
                break;
            end
        end
        chk("drain_valid_cycles", nv, 87);
        chk("drain_last_slot", last, 127);
        chk("drain_cycles", nd, 8);
        chk("drain_then_idle", o_Idle, 1);
        tick();
        chk("rerun_valid", o_Valid, 1);
        chk("rerun_slot", o_VoiceOperator, 0);
        chk("rerun_fs", o_FrameStart, 1);

        // Reset mid-frame with a write request outstanding.
        to_slot(90);
        cfg_vld = 1; cfg_addr = 7'd5; cfg_data = 16'h1234;
        do_reset();

        // Random traffic against the model.
        en = 1;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(63) == 0) en = !en;
            note_vld   = ($urandom_range(3) == 0);
            note_voice = 4'($urandom_range(15));
            note_on    = 1'($urandom_range(1));
            if (!cfg_vld && $urandom_range(3) == 0) begin
                cfg_vld  = 1;
                cfg_addr = ($urandom_range(1) == 1) ? 7'(m_slot) : 7'($urandom_range(NSLOT - 1));
                cfg_data = 16'($urandom);
            end
            tick();
            if (m_we) cfg_vld = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/operator_sequencer.md
OPERATOR_SEQUENCER -- requirements
Module: operator_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning): NUM_VOICES, 16, voices per frame; OPS_PER_VOICE, 8, operator slots per voice; DRAIN_CYCLES, 8, downstream modulator pipeline depth.
REQ-002 i_Clock  in  1  sole clock; all state on its rising edge.
REQ-003 i_Reset  in  1  asynchronous, active-high reset.
REQ-004 i_Enable  in  1  run request; level-sensitive.
REQ-005 o_VoiceOperator  out  VOICE_OPERATOR_ID  current slot, ID = voice*OPS_PER_VOICE + op.
REQ-006 o_Valid  out  1  o_VoiceOperator/o_NoteOn valid this cycle.
REQ-007 o_NoteOn  out  1  note state of the voice in o_VoiceOperator.
REQ-008 o_FrameStart  out  1  one-cycle pulse coincident with slot ID 0.
REQ-009 o_Idle  out  1  high only in IDLE.
REQ-010 i_NoteValid / i_NoteVoice / i_NoteOn  in  1 / VOICE_ID / 1  host note event, always accepted.
REQ-011 i_CfgValid / o_CfgReady / i_CfgAddr / i_CfgData  in / out / in / in  1 / 1 / VOICE_OPERATOR_ID / 16  algorithm-write handshake.
REQ-012 o_AlgorithmWriteEnable / o_ConfigWriteAddr / o_ConfigWriteData  out  1 / VOICE_OPERATOR_ID / 16  write port to the modulator.

Function
REQ-013 FSM SHALL have states IDLE, RUN, DRAIN.
- IDLE->RUN when i_Enable=1.
- RUN->DRAIN after the last slot (NUM_VOICES*OPS_PER_VOICE-1) is issued with i_Enable=0.
- DRAIN->IDLE after DRAIN_CYCLES cycles.
REQ-014 In RUN, slot counter SHALL increment by 1 per cycle, wrap from N-1 to 0, and hold o_Valid=1; o_Valid=0 in IDLE and DRAIN.
REQ-015 First RUN cycle SHALL issue slot 0 with o_FrameStart=1; deasserting i_Enable mid-frame SHALL NOT truncate the frame.
REQ-016 i_Enable reasserted during DRAIN SHALL be ignored until IDLE is reached; RUN entry is then the next cycle.
REQ-017 Note events SHALL be written to a pending table; the pending table SHALL copy to the active table on the cycle o_FrameStart=1, so a voice never changes note state mid-frame.
REQ-018 Two events for one voice in one frame: the later SHALL win. An event coinciding with the copy cycle SHALL land in the next frame.
REQ-019 o_CfgReady SHALL be 0 only when state=RUN and i_CfgAddr equals the slot being issued this cycle; otherwise 1.
REQ-020 Accept (i_CfgValid & o_CfgReady) SHALL drive o_AlgorithmWriteEnable=1 with registered address/data exactly one cycle later. At most one write per cycle; the host holds the request stable until accepted.
REQ-021 Outputs SHALL be registered; o_NoteOn SHALL be aligned to o_VoiceOperator in the same cycle.

Reset
REQ-022 i_Reset SHALL, regardless of state, force: IDLE, slot counter 0, o_Valid=0, o_FrameStart=0, o_Idle=1, o_NoteOn=0, o_AlgorithmWriteEnable=0, o_ConfigWriteAddr=0, o_ConfigWriteData=0, both note tables cleared.
REQ-023 A write accepted in the cycle before reset SHALL be discarded; o_CfgReady SHALL follow REQ-019 (1 in IDLE).

Configuration
REQ-024 With SEQ_FRAME_COUNTER_EN defined, output o_FrameCount (16 bits, reset 0) SHALL increment on each o_FrameStart and wrap 0xFFFF->0. Without the macro, the port and counter SHALL be absent.

Structure
REQ-025 The synth package SHALL hold NUM_VOICES, OPS_PER_VOICE, the VOICE_ID and VOICE_OPERATOR_ID types, and the state enum.
REQ-026 The pending/active note storage SHALL be one sub-module, note_state_table.

Verification
REQ-027 Reset, then i_Enable=1 for 300 cycles -> slot IDs 0..127, 0..; o_FrameStart on cycles 1 and 129.
REQ-028 Drop i_Enable at slot 40 -> slots continue to 127, o_Valid=0 for 8 cycles, then o_Idle=1.
REQ-029 Note-on voice 3 issued at slot 50 -> o_NoteOn=0 for slots 24..31 this frame, =1 for slots 24..31 next frame.
REQ-030 Cfg write addr 17, data 0x07FF, presented while slot 17 is issuing -> o_CfgReady=0 that cycle; accepted next cycle; o_AlgorithmWriteEnable pulses one cycle later with addr 17, data 0x07FF.
REQ-031 Assert i_Reset mid-frame at slot 90 with a write pending -> all outputs at reset values, no write pulse.
REQ-032 With SEQ_FRAME_COUNTER_EN, run 3 frames -> o_FrameCount=3.
